// File: rtl/alu_iter_ctrl_pkg.sv
// Shared constants for the iterative ALU controller and the 4-bit ALU.
// State codes, ALU op codes and width defaults.
package alu_iter_ctrl_pkg;

  localparam int W_DEF  = 4;
  localparam int CW_DEF = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_SRA = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

endpackage

// File: rtl/alu4.sv
// Combinational ALU: arithmetic/logical shift right, subtract, add.
// Wired beside alu_iter_ctrl in the top level.
module alu4
  import alu_iter_ctrl_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [1:0]   in_c,
  input  logic [1:0]   op,
  output logic [W-1:0] ans
);

  logic signed [W-1:0] sa;

  always_comb begin
    sa  = in_a;
    ans = '0;
    unique case (op)
      OP_SRA:  ans = W'(sa >>> in_c);
      OP_SRL:  ans = in_a >> in_c;
      OP_SUB:  ans = in_a - in_b;
      OP_ADD:  ans = in_a + in_b;
      default: ans = '0;
    endcase
  end

endmodule

// File: rtl/alu_iter_ctrl.sv
// Applies one ALU op repeatedly to an accumulator, iter times.
// Optional sticky carry/borrow output under `WRAP_FLAG_EN.
module alu_iter_ctrl
  import alu_iter_ctrl_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  init_val,
  input  logic [W-1:0]  operand,
  input  logic [1:0]    shamt,
  input  logic [1:0]    op_sel,
  input  logic [CW-1:0] iter,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [1:0]    alu_c,
  output logic [1:0]    alu_op,
  input  logic [W-1:0]  alu_ans,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
`ifdef WRAP_FLAG_EN
  output logic          wrap,
`endif
  output logic [CW-1:0] remaining
);

  logic [1:0]    state;
  logic [W-1:0]  acc;
  logic [W-1:0]  opnd;
  logic [1:0]    sh;
  logic [1:0]    ops;
  logic [CW-1:0] rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      opnd  <= '0;
      sh    <= '0;
      ops   <= '0;
      rem   <= '0;
`ifdef WRAP_FLAG_EN
      wrap  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc   <= init_val;
            opnd  <= operand;
            sh    <= shamt;
            ops   <= op_sel;
            rem   <= iter;
            state <= (iter != '0) ? RUN : DONE;
`ifdef WRAP_FLAG_EN
            wrap  <= 1'b0;
`endif
          end
        end
        RUN: begin
          acc <= alu_ans;
          if (rem != '0)
            rem <= rem - CW'(1);
          if (rem <= CW'(1))
            state <= DONE;
`ifdef WRAP_FLAG_EN
          // unsigned carry/borrow seen as the result moving the wrong way
          if (ops == OP_ADD && alu_ans < acc)
            wrap <= 1'b1;
          if (ops == OP_SUB && alu_ans > acc)
            wrap <= 1'b1;
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_a     = acc;
  assign alu_b     = opnd;
  assign alu_c     = sh;
  assign alu_op    = ops;
  assign result    = acc;
  assign remaining = rem;
  assign busy      = (state == RUN) || (state == DONE);
  assign done      = (state == DONE);

endmodule

// File: doc/alu_iter_ctrl.md
Name: alu_iter_ctrl

Overview:
- Sequential controller that drives the 4-bit ALU and captures its result, so one ALU operation is applied repeatedly to an accumulator.
- Sits directly around the ALU: drives its inA/inB/inC/op and consumes its combinational ans.
- Accepts a command with a start pulse and reports busy, a one-cycle done pulse and a held 4-bit result.
- The counter top level uses it for multi-step add/sub/shift sequences.

Parameters:
- W, 4, datapath width; must equal the ALU width.
- CW, 4, width of the iteration count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- init_val  input  W  initial accumulator value.
- operand  input  W  inB operand for add/sub.
- shamt  input  2  inC shift amount.
- op_sel  input  2  ALU op: 00 arithmetic shift right, 01 logical shift right, 10 A-B, 11 A+B.
- iter  input  CW  number of ALU applications (0..15).
- alu_a  output  W  to ALU inA; always equals acc.
- alu_b  output  W  to ALU inB; latched operand.
- alu_c  output  2  to ALU inC; latched shamt.
- alu_op  output  2  to ALU op; latched op_sel.
- alu_ans  input  W  from ALU ans, combinational in the same cycle.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse in DONE.
- result  output  W  accumulator value; held until the next accepted start.
- remaining  output  CW  iterations still to apply.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high, named clk and reset as elsewhere in the codebase.
- Reset values: state=IDLE, acc=0, operand/shamt/op latches=0, remaining=0, busy=0, done=0.
- Reset mid-operation: returns to IDLE on the next edge, discarding the command. No done pulse is issued.
- State IDLE:
  - On start=1 at an edge: latch init_val into acc, operand, shamt and op_sel; load remaining=iter.
  - Next state is RUN if iter!=0, otherwise DONE.
  - start=0: stay in IDLE, outputs hold.
- State RUN, at each edge:
  - acc <= alu_ans; remaining <= remaining-1.
  - When remaining==1 at that edge, go to DONE.
- State DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: with start accepted at edge E0, done is high in the cycle after edge E0+N, where N=iter (N=0 gives done in the cycle right after E0).
- Command handling:
  - start while busy is ignored; there is no queueing.
  - start in the same cycle that DONE is high is also ignored. The earliest new start is the cycle in IDLE.
- Arithmetic:
  - All results are modulo 2^W; wrap-around is silent.
  - Shift semantics belong to the ALU. The controller never modifies alu_ans.
- Output timing: result=acc at all times, so it is valid and stable from the DONE cycle until the next accepted start. The command latches are stable for the whole RUN.
- Ports and counter: no combinational path from start to any output. remaining never underflows.

Optional Feature:
- Macro: WRAP_FLAG_EN.
- With the macro defined:
  - Extra output port wrap, 1 bit, sticky; cleared on reset and on an accepted start.
  - Set in a RUN cycle when op=11 and alu_ans < acc (unsigned carry-out).
  - Set in a RUN cycle when op=10 and alu_ans > acc (unsigned borrow).
  - Shifts never set it. wrap is valid alongside result.
- Without the macro: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - State enumeration IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Op code constants OP_SRA=2'b00, OP_SRL=2'b01, OP_SUB=2'b10, OP_ADD=2'b11, also used by the ALU bench.
  - Width defaults W=4, CW=4.
- No sub-module inside this block; the ALU stays a separate instance wired beside it in the top level.
- The testbench instantiates both this block and the ALU.

Test Plan:
- ADD loop: init_val=5, operand=3, op=11, iter=4 -> busy 4 RUN cycles; done pulse once; result=4'd1 (17 mod 16); wrap=1 when the macro is enabled.
- SUB underflow: init_val=2, operand=3, op=10, iter=1 -> result=4'hF, done in the cycle after edge E0+1; wrap=1.
- Arithmetic shift: init_val=4'b1000, shamt=1, op=00, iter=2 -> result=4'b1110.
- Logical shift: init_val=4'b1000, shamt=1, op=01, iter=3 -> result=4'b0001.
- Zero iterations: iter=0, init_val=9 -> DONE immediately after E0; result=9; remaining=0.
- Reset mid-run and start while busy:
  - Extra start pulses during RUN are ignored; result matches the original command.
  - reset asserted during RUN -> next cycle IDLE, busy=0, result=0, no done pulse.
